// File: rtl/shared_delay_scheduler.sv
// shared_delay_scheduler: two-requester round-robin arbiter for one shared
// programmable delay timer. The winner's delay is counted in ticks of
// TICK_DIV system clocks; a one-cycle done pulse marks expiry.
module shared_delay_scheduler #(
  parameter int unsigned TICK_DIV    = 50,
  parameter int unsigned DELAY_WIDTH = 20,
  parameter int unsigned PRESC_WIDTH = 6
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_a,
  input  logic [DELAY_WIDTH-1:0] delay_a,
  input  logic                   req_b,
  input  logic [DELAY_WIDTH-1:0] delay_b,
  input  logic                   cancel,
  output logic [1:0]             grant,
  output logic                   done_a,
  output logic                   done_b,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [PRESC_WIDTH-1:0] PRESC_LAST = PRESC_WIDTH'(TICK_DIV - 1);
  localparam logic [DELAY_WIDTH-1:0] REM_ONE    = DELAY_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [1:0]             grant_q, grant_d;
  logic                   done_a_q, done_a_d;
  logic                   done_b_q, done_b_d;
  logic                   busy_q, busy_d;
  logic [PRESC_WIDTH-1:0] presc_q, presc_d;
  logic [DELAY_WIDTH-1:0] remaining_q, remaining_d;
  // last_served: 1'b0 = A, 1'b1 = B
  logic                   last_q, last_d;
  logic                   win_b;

  // Round-robin pick: B wins when it is the sole requester, or on a tie
  // when A was the last one served.
  always_comb begin
    win_b = req_b && (!req_a || !last_q);
  end

  // Next-state, datapath and registered-output computation.
  // A grant always enters COUNT first; a zero latched delay leaves COUNT on
  // the following edge, which places the done cycle at E0+1 as required.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    remaining_d = remaining_q;
    presc_d     = presc_q;
    done_a_d    = 1'b0;
    done_b_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          state_d     = COUNT;
          grant_d     = win_b ? 2'b10 : 2'b01;
          last_d      = win_b;
          remaining_d = win_b ? delay_b : delay_a;
          presc_d     = '0;
        end else begin
          grant_d = '0;
        end
      end

      COUNT: begin
        if (cancel) begin
          state_d = IDLE;
          grant_d = '0;
          presc_d = '0;
        end else if (remaining_q == '0) begin
          state_d  = DONE;
          done_a_d = grant_q[0];
          done_b_d = grant_q[1];
        end else if (presc_q == PRESC_LAST) begin
          presc_d     = '0;
          remaining_d = remaining_q - REM_ONE;
          if (remaining_q == REM_ONE) begin
            state_d  = DONE;
            done_a_d = grant_q[0];
            done_b_d = grant_q[1];
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        grant_d = '0;
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; asynchronous reset clears everything and
  // marks B as last served so A wins the first tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      done_a_q    <= 1'b0;
      done_b_q    <= 1'b0;
      busy_q      <= 1'b0;
      presc_q     <= '0;
      remaining_q <= '0;
      last_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      done_a_q    <= done_a_d;
      done_b_q    <= done_b_d;
      busy_q      <= busy_d;
      presc_q     <= presc_d;
      remaining_q <= remaining_d;
      last_q      <= last_d;
    end
  end

  assign grant  = grant_q;
  assign done_a = done_a_q;
  assign done_b = done_b_q;
  assign busy   = busy_q;

endmodule
